// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: datapath width, reset PC, fetch FSM states, opcode constants.
package rv32i_pkg;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    TRAP  = 2'd3
  } fetch_state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  function automatic logic [6:0] opcode_of(input logic [31:0] word);
    return word[6:0];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory req/ack plus execute-side valid/ready and branch inputs.
interface fetch_unit_if import rv32i_pkg::*; #(
  parameter int unsigned XLEN = rv32i_pkg::XLEN
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            imem_ack;
  logic [31:0]     instr;
  logic            instr_valid;
  logic            instr_ready;
  logic            pc_src;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            misalign_trap;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, misalign_trap,
    input  imem_rdata, imem_ack, instr_ready, pc_src, imm_ext
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4, misalign_trap,
    output imem_rdata, imem_ack, instr_ready, pc_src, imm_ext
  );

endinterface

// File: rtl/fetch_unit_pc_next.sv
// Next-PC datapath: pc+4, branch target, selection and alignment check.
// Optional FETCH_MISALIGN_TRAP_EN exposes the misalignment flag instead of forcing alignment.
module pc_next import rv32i_pkg::*; #(
  parameter int unsigned XLEN = rv32i_pkg::XLEN
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            pc_src_i,
  input  logic [XLEN-1:0] imm_ext_i,
  output logic [XLEN-1:0] pc_plus4_o,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic            misaligned_o,
`endif
  output logic [XLEN-1:0] next_pc_d_o
);

  logic [XLEN-1:0] target;
  logic [XLEN-1:0] sel;

  always_comb begin
    pc_plus4_o = pc_i + XLEN'(4);
    target     = pc_i + imm_ext_i;
    sel        = pc_src_i ? target : pc_plus4_o;
`ifdef FETCH_MISALIGN_TRAP_EN
    misaligned_o = pc_src_i && (target[1:0] != 2'b00);
    next_pc_d_o  = sel;
`else
    // Without the trap, low bits are dropped so the PC can never go misaligned.
    next_pc_d_o  = sel & {{(XLEN-2){1'b1}}, 2'b00};
`endif
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: PC register, imem req/ack, valid/ready hand-off to execute.
// Optional FETCH_MISALIGN_TRAP_EN adds a terminal TRAP state on misaligned branch targets.
module fetch_unit import rv32i_pkg::*; #(
  parameter int unsigned    XLEN     = rv32i_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = rv32i_pkg::RESET_PC
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  fi
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            req_q;
  logic            valid_q;
  logic [XLEN-1:0] next_pc_d;
  logic [XLEN-1:0] pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            misaligned;
  logic            trap_q;
`endif

  pc_next #(.XLEN(XLEN)) u_pc_next (
    .pc_i        (pc_q),
    .pc_src_i    (fi.pc_src),
    .imm_ext_i   (fi.imm_ext),
    .pc_plus4_o  (pc_plus4),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misaligned_o(misaligned),
`endif
    .next_pc_d_o (next_pc_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: begin
          if (fi.imem_ack) begin
            instr_q <= fi.imem_rdata;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= VALID;
          end
        end
        VALID: begin
          if (fi.instr_ready) begin
            valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misaligned) begin
              trap_q  <= 1'b1;
              state_q <= TRAP;
            end else begin
              pc_q    <= next_pc_d;
              req_q   <= 1'b1;
              state_q <= REQ;
            end
`else
            pc_q    <= next_pc_d;
            req_q   <= 1'b1;
            state_q <= REQ;
`endif
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        TRAP: state_q <= TRAP;
`endif
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign fi.imem_req    = req_q;
  assign fi.imem_addr   = pc_q;
  assign fi.instr       = instr_q;
  assign fi.instr_valid = valid_q;
  assign fi.pc          = pc_q;
  assign fi.pc_plus4    = pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fi.misalign_trap = trap_q;
`else
  assign fi.misalign_trap = 1'b0;
`endif

endmodule
